// File: rtl/seq_shift_reg.sv
// Multi-cycle universal shift register: parallel load plus a start/busy/done sequence of single-bit shifts.
// Optional `SEQ_SHIFT_ABORT_EN adds an abort input that cancels an in-progress shift sequence.
module seq_shift_reg #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               load,
  input  logic               start,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic               ser_in,
  input  logic [SHAMT_W-1:0] shamt,
`ifdef SEQ_SHIFT_ABORT_EN
  input  logic               abort,
`endif
  output logic [WIDTH-1:0]   q,
  output logic               ser_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOGIC  = 2'b00;
  localparam logic [1:0] MODE_ARITH  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;

  state_t             state_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               ser_out_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [SHAMT_W-1:0] cnt_reg;
  logic               dir_reg;
  logic [1:0]         mode_reg;

  logic               fill_right;
  logic               fill_left;
  logic [WIDTH-1:0]   shr_next;
  logic [WIDTH-1:0]   shl_next;
  logic [WIDTH-1:0]   shift_next;
  logic               out_bit_next;

  // Fill bits depend on the latched mode, never on the live mode input.
  always_comb begin
    fill_right = ser_in;
    fill_left  = ser_in;
    case (mode_reg)
      MODE_LOGIC: begin
        fill_right = 1'b0;
        fill_left  = 1'b0;
      end
      MODE_ARITH: begin
        fill_right = q_reg[WIDTH-1];
        fill_left  = 1'b0;
      end
      MODE_ROTATE: begin
        fill_right = q_reg[0];
        fill_left  = q_reg[WIDTH-1];
      end
      default: begin
        fill_right = ser_in;
        fill_left  = ser_in;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_top
        assign shr_next[gi] = fill_right;
      end else begin : g_mid_r
        assign shr_next[gi] = q_reg[gi+1];
      end
      if (gi == 0) begin : g_bot
        assign shl_next[gi] = fill_left;
      end else begin : g_mid_l
        assign shl_next[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  assign shift_next   = dir_reg ? shl_next : shr_next;
  assign out_bit_next = dir_reg ? q_reg[WIDTH-1] : q_reg[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      q_reg       <= '0;
      ser_out_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      cnt_reg     <= '0;
      dir_reg     <= 1'b0;
      mode_reg    <= 2'b00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
          if (load) begin
            q_reg <= load_val;
          end else if (start) begin
            dir_reg  <= dir;
            mode_reg <= mode;
            if (shamt == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_SHIFT;
              cnt_reg   <= shamt;
              busy_reg  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
`ifdef SEQ_SHIFT_ABORT_EN
          // Abort wins over the final count; q keeps the shifts done so far.
          if (abort) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
`endif
            q_reg       <= shift_next;
            ser_out_reg <= out_bit_next;
            cnt_reg     <= cnt_reg - SHAMT_W'(1);
            if (cnt_reg == SHAMT_W'(1)) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
`ifdef SEQ_SHIFT_ABORT_EN
          end
`endif
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign q       = q_reg;
  assign ser_out = ser_out_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_seq_shift_reg.sv
// Self-checking bench for seq_shift_reg: directed cases plus random transactions against an arithmetic reference.
module tb_seq_shift_reg;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 4;

  logic               clk;
  logic               reset;
  logic [WIDTH-1:0]   load_val;
  logic               load;
  logic               start;
  logic               dir;
  logic [1:0]         mode;
  logic               ser_in;
  logic [SHAMT_W-1:0] shamt;
`ifdef SEQ_SHIFT_ABORT_EN
  logic               abort;
`endif
  logic [WIDTH-1:0]   q;
  logic               ser_out;
  logic               busy;
  logic               done;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q;
  logic       exp_ser;

  seq_shift_reg #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .reset(reset), .load_val(load_val), .load(load), .start(start),
    .dir(dir), .mode(mode), .ser_in(ser_in), .shamt(shamt),
`ifdef SEQ_SHIFT_ABORT_EN
    .abort(abort),
`endif
    .q(q), .ser_out(ser_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result of n successive single-bit shifts, computed in one step with wide arithmetic.
  function automatic logic [7:0] ref_shift(input logic [7:0] v, input logic d, input logic [1:0] m,
                                           input logic s, input int n);
    int r;
    int signed sv;
    logic [31:0] w;
    r = n % 8;
    if (!d) begin
      case (m)
        2'b00: w = {24'b0, v} >> n;
        2'b01: begin sv = $signed({{24{v[7]}}, v}); sv = sv >>> n; w = sv; end
        2'b10: w = ({24'b0, v} >> r) | ({24'b0, v} << (8 - r));
        default: w = {{24{s}}, v} >> n;
      endcase
    end else begin
      case (m)
        2'b00, 2'b01: w = {24'b0, v} << n;
        2'b10: w = ({24'b0, v} << r) | ({24'b0, v} >> (8 - r));
        default: begin w = {v, {24{s}}} << n; w = w >> 24; end
      endcase
    end
    return w[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_q(input logic [7:0] v);
    @(negedge clk);
    load = 1'b1; load_val = v; start = 1'b0;
    @(negedge clk);
    load = 1'b0;
    exp_q = v;
    check("load_q", 32'(q), 32'(v));
  endtask

  task automatic run_shift(input logic d, input logic [1:0] m, input logic s,
                           input logic [3:0] sh, input bit noise, input string tag);
    int busy_cnt, done_cnt, done_cyc;
    logic [7:0] q0, v1;
    q0 = exp_q;
    @(negedge clk);
    dir = d; mode = m; ser_in = s; shamt = sh; start = 1'b1; load = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int cyc = 1; cyc <= int'(sh) + 4; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (busy && noise) begin
        start    = 1'($urandom_range(0, 1));
        load     = 1'($urandom_range(0, 1));
        load_val = 8'($urandom);
        dir      = 1'($urandom_range(0, 1));
        mode     = 2'($urandom);
        shamt    = 4'($urandom);
      end else begin
        start = 1'b0;
        load  = 1'b0;
      end
    end
    exp_q = ref_shift(q0, d, m, s, int'(sh));
    if (sh != 4'd0) begin
      v1 = ref_shift(q0, d, m, s, int'(sh) - 1);
      exp_ser = d ? v1[7] : v1[0];
    end
    check({tag, ".q"}, 32'(q), 32'(exp_q));
    check({tag, ".ser_out"}, 32'(ser_out), 32'(exp_ser));
    check({tag, ".busy_cycles"}, busy_cnt, 32'(sh));
    check({tag, ".done_cycle"}, done_cyc, 32'(sh) + 1);
    check({tag, ".done_width"}, done_cnt, 1);
    $display("%s: q0=%02h dir=%0d mode=%0d ser_in=%0d shamt=%0d -> q=%02h ser_out=%0d busy=%0d done@%0d",
             tag, q0, d, m, s, sh, q, ser_out, busy_cnt, done_cyc);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; load = 1'b0; start = 1'b0; load_val = '0; dir = 1'b0;
    mode = 2'b00; ser_in = 1'b0; shamt = '0;
`ifdef SEQ_SHIFT_ABORT_EN
    abort = 1'b0;
`endif
    exp_q = 8'h00; exp_ser = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.q", 32'(q), 0);
    check("reset.ser_out", 32'(ser_out), 0);
    check("reset.busy", 32'(busy), 0);
    check("reset.done", 32'(done), 0);
    reset = 1'b0;

    load_q(8'hB5);
    check("t1.busy", 32'(busy), 0);
    check("t1.done", 32'(done), 0);
    check("t1.ser_out", 32'(ser_out), 0);

    load_q(8'h96);
    run_shift(1'b0, 2'b01, 1'b0, 4'd3, 1'b0, "t2_asr3");
    check("t2.const_q", 32'(q), 32'hF2);
    check("t2.const_ser", 32'(ser_out), 1);

    load_q(8'h81);
    run_shift(1'b1, 2'b10, 1'b0, 4'd9, 1'b0, "t3_rol9");
    check("t3.const_q", 32'(q), 32'h03);

    load_q(8'h5A);
    run_shift(1'b0, 2'b00, 1'b0, 4'd0, 1'b0, "t4_zero");
    check("t4.const_q", 32'(q), 32'h5A);

    load_q(8'h00);
    run_shift(1'b0, 2'b11, 1'b1, 4'd2, 1'b1, "t5_serial");
    check("t5.const_q", 32'(q), 32'hC0);

    load_q(8'hFF);
    run_shift(1'b0, 2'b00, 1'b0, 4'd15, 1'b1, "lsr_sat");
    load_q(8'h80);
    run_shift(1'b0, 2'b01, 1'b0, 4'd12, 1'b1, "asr_sat");

    for (int i = 0; i < 24; i++) begin
      if ((i % 3) == 0) load_q(8'($urandom));
      run_shift(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 1)),
                4'($urandom), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of a shift sequence.
    load_q(8'hA7);
    @(negedge clk);
    dir = 1'b0; mode = 2'b00; shamt = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6.q", 32'(q), 0);
    check("t6.busy", 32'(busy), 0);
    check("t6.done", 32'(done), 0);
    check("t6.ser_out", 32'(ser_out), 0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("t6.no_done", done_seen, 0);
    exp_q = 8'h00; exp_ser = 1'b0;
    $display("t6_reset: q=%02h busy=%0d done=%0d", q, busy, done);

`ifdef SEQ_SHIFT_ABORT_EN
    load_q(8'hB4);
    @(negedge clk);
    dir = 1'b1; mode = 2'b10; shamt = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort.q", 32'(q), 32'(ref_shift(8'hB4, 1'b1, 2'b10, 1'b0, 2)));
    check("abort.busy", 32'(busy), 0);
    done_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort.no_done", done_seen, 0);
    $display("abort: q=%02h busy=%0d", q, busy);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
